// File: rtl/div_unit.sv
// Multi-cycle restoring divider: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish on the next edge.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             z
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic [CW-1:0]    cnt;
    logic             qneg, rneg, sel_rem;

    logic             signed_op, a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] q_fin, r_fin, res;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_abs     = a_neg ? (~a + ONE) : a;
        b_abs     = b_neg ? (~b + ONE) : b;
        div_zero  = (b == '0);
        ovf       = signed_op && (a == MINV) && (b == '1);

        // partial remainder stays below the divisor, so the borrow bit alone decides the quotient bit
        shifted   = {rem, quo[WIDTH-1]};
        trial     = shifted - {1'b0, dvs};

        q_fin     = qneg ? (~quo + ONE) : quo;
        r_fin     = rneg ? (~rem + ONE) : rem;
        res       = sel_rem ? r_fin : q_fin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            sel_rem <= 1'b0;
            f       <= '0;
            z       <= 1'b1;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    sel_rem <= op[1];
                    dvs     <= b_abs;
                    // special cases preload the final quotient/remainder and skip straight to the last count
                    if (div_zero) begin
                        quo  <= '1;
                        rem  <= a;
                        qneg <= 1'b0;
                        rneg <= 1'b0;
                        cnt  <= LAST;
                    end else if (ovf) begin
                        quo  <= MINV;
                        rem  <= '0;
                        qneg <= 1'b0;
                        rneg <= 1'b0;
                        cnt  <= LAST;
                    end else begin
                        quo  <= a_abs;
                        rem  <= '0;
                        qneg <= a_neg ^ b_neg;
                        rneg <= a_neg;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    if (cnt == LAST) begin
                        f <= res;
                        z <= (res == '0);
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem <= trial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         busy, done;
    logic [W-1:0] f;
    logic         z;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [W-1:0] last_f;
    logic         last_z;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
        .busy(busy), .done(done), .f(f), .z(z)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W-1:0] sx, sy;
        sx = x;
        sy = y;
        if (y == '0)                                  return o[1] ? x : '1;
        if (!o[0] && x == MINV && y == '1)           return o[1] ? '0 : MINV;
        case (o)
            2'b00:   return sx / sy;
            2'b01:   return x / y;
            2'b10:   return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == '0) || (!o[0] && x == MINV && y == '1);
    endfunction

    task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; start is sampled on the next edge (edge k).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int poke);
        logic [W-1:0] exp_f;
        int lat, seen;
        exp_f = model(o, x, y);
        lat   = is_special(o, x, y) ? 1 : 33;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        checkb("busy_after_accept", busy, 1'b1);
        checkb("no_done_at_accept", done, 1'b0);
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                seen = n;
                break;
            end
            checkw("f_stable_in_calc", f, last_f);
            checkb("z_stable_in_calc", z, last_z);
            checkb("busy_in_calc", busy, 1'b1);
            if (poke != 0 && n == poke) begin
                start = 1'b1; a = 1; b = 1; op = 2'b01;
            end
        end
        checkw("latency", W'(seen), W'(lat));
        checkw("result_f", f, exp_f);
        checkb("result_z", z, exp_f == '0);
        checkb("busy_in_done", busy, 1'b1);
        last_f = exp_f;
        last_z = (exp_f == '0);
        start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        checkb("done_one_cycle", done, 1'b0);
        checkb("start_in_done_ignored", busy, 1'b0);
    endtask

    task automatic abort_test();
        bit got_done;
        op = 2'b01; a = 100; b = 7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkb("abort_busy", busy, 1'b0);
        checkb("abort_done", done, 1'b0);
        checkw("abort_f", f, '0);
        checkb("abort_z", z, 1'b1);
        last_f = '0;
        last_z = 1'b1;
        got_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) got_done = 1'b1;
        end
        checkb("abort_no_done", got_done, 1'b0);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        int unsigned  kind;
        rst = 1'b1; start = 1'b1; a = 5; b = 1; op = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        checkb("reset_busy", busy, 1'b0);
        checkb("reset_done", done, 1'b0);
        checkw("reset_f", f, '0);
        checkb("reset_z", z, 1'b1);
        @(posedge clk); #1;
        checkb("start_with_rst_ignored", busy, 1'b0);
        last_f = '0;
        last_z = 1'b1;

        run_op(2'b01, 100, 7, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 2, 0);
        run_op(2'b00, 32'hFFFF_FFF9, 2, 0);
        run_op(2'b01, 5, 0, 0);
        run_op(2'b11, 5, 0, 0);
        run_op(2'b00, MINV, 32'hFFFF_FFFF, 0);
        run_op(2'b10, MINV, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'hFFFF_FFF9, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 0, 0);
        run_op(2'b01, MINV, 32'hFFFF_FFFF, 0);
        run_op(2'b11, 32'hFFFF_FFFF, 1, 0);
        run_op(2'b01, 100, 7, 10);
        abort_test();

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            kind = $urandom % 8;
            case (kind)
                0:       rb = '0;
                1:       begin ra = MINV; rb = '1; end
                2, 3:    rb = $urandom % 16;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; all values below assume WIDTH=32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, the dividend.
REQ-006 The block SHALL have port b, input, WIDTH, the divisor.
REQ-007 The block SHALL have port op, input, 2, the operation select: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in flight (state CALC or DONE).
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking f and z valid.
REQ-010 The block SHALL have port f, output, WIDTH, the registered result.
REQ-011 The block SHALL have port z, output, 1, the registered zero flag, 1 iff f == 0.

Function
REQ-012 The block SHALL implement the states IDLE, CALC and DONE.
REQ-013 The block SHALL accept a request in IDLE when start=1 at a clock edge and SHALL latch a, b and op at that edge; call that edge k.
REQ-014 The block SHALL ignore start in CALC and DONE, with no latch and no effect on the operation in flight.
REQ-015 For signed ops, the block SHALL latch absolute values of a and b, the quotient sign (a[31] XOR b[31]) and the remainder sign (a[31]); for unsigned ops it SHALL take the operands as-is.
REQ-016 On accepting a normal request, the block SHALL enter CALC and perform restoring division one quotient bit per cycle, MSB first, for exactly WIDTH cycles (edges k+1..k+32).
REQ-017 After the last iteration, the block SHALL enter DONE, apply sign correction (two's-complement negate), select quotient for op 00/01 or remainder for op 10/11, and register f and z.
REQ-018 For a normal operation, the block SHALL assert done with f valid in the cycle following edge k+33, i.e. done is visible 33 cycles after the accepting edge.
REQ-019 For divide-by-zero (b == 0), the block SHALL go from IDLE directly to DONE: quotient all ones (0xFFFFFFFF) for both DIV and DIVU; remainder = a for both REM and REMU.
REQ-020 For signed overflow (op 00/10, a == 0x80000000, b == 0xFFFFFFFF), the block SHALL go directly to DONE with quotient 0x80000000 and remainder 0.
REQ-021 Special cases SHALL show done in the cycle after edge k+1; divide-by-zero SHALL take priority over overflow.
REQ-022 The block SHALL hold done=1 for exactly one cycle (the DONE state); the next edge SHALL always return it to IDLE.
REQ-023 The block SHALL keep f and z stable from done until the next accepted request completes; they SHALL NOT change during CALC.
REQ-024 The block SHALL treat a start asserted in the DONE cycle as ignored, so back-to-back requests need start held, or reasserted, in IDLE.
REQ-025 The block SHALL compute quotient and remainder so that they satisfy a == q*b + r, with |r| < |b| and sign(r) == sign(a) or r == 0.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL go to state IDLE with busy=0, done=0, f=0, z=1 and internal registers cleared.
REQ-027 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.
REQ-028 The block SHALL treat start sampled together with rst=1 as ignored.

Verification
REQ-029 Bench case: DIVU a=100, b=7, start one cycle -> busy high for 33 cycles, then done pulse with f=14 and z=0.
REQ-030 Bench case: REM a=0xFFFFFFF9 (-7), b=2 -> f=0xFFFFFFFF (-1); DIV with the same operands -> f=0xFFFFFFFD (-3).
REQ-031 Bench case: DIVU a=5, b=0 -> done one cycle after acceptance with f=0xFFFFFFFF; REMU a=5, b=0 -> f=5.
REQ-032 Bench case: DIV a=0x80000000, b=0xFFFFFFFF -> f=0x80000000; REM with the same operands -> f=0 and z=1; both one-cycle latency.
REQ-033 Bench case: start pulsed at cycle 10 of an active DIVU 100/7 with a=1, b=1 -> ignored, and the result is still f=14 at the original done time.
REQ-034 Bench case: rst=1 at cycle 15 of an operation -> next cycle shows busy=0, f=0, z=1, and no done pulse follows.
